udp_tx_arb: RTL and testbench
=============================

UDP_TX_ARB -- requirements
Module: udp_tx_arb

Interface
REQ-001 Parameter IFG_CYCLES, default 12: idle clocks enforced after each frame ends.
REQ-002 Parameter START_HOLD, default 4: clocks tx_start_en is held high; range 1..15.
REQ-003 Parameter TIMEOUT, default 16'd4000: maximum clocks from start to tx_done before abort.
REQ-004 clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req0/req1  in  1  level frame request from requester 0/1; held until done or timeout.
REQ-007 len0/len1  in  16  payload byte count; stable while req high.
REQ-008 ip0/ip1  in  32  destination IP; stable while req high.
REQ-009 mac0/mac1  in  48  destination MAC; stable while req high.
REQ-010 data0/data1  in  8  payload byte from requester FIFO.
REQ-011 grant0/grant1  out  1  registered; requester owns the transmitter.
REQ-012 rd_req0/rd_req1  out  1  payload read request forwarded to granted requester.
REQ-013 done0/done1  out  1  one-clock pulse: frame completed for that requester.
REQ-014 tx_start_en  out  1  start level to the UDP transmitter.
REQ-015 tx_byte_num  out  16  latched payload length to transmitter.
REQ-016 des_ip  out  32, des_mac  out  48  latched destination to transmitter.
REQ-017 tx_data  out  8  payload mux to transmitter.
REQ-018 tx_req  in  1  transmitter payload request; tx_done  in  1  transmitter end-of-frame pulse.
REQ-019 err_timeout  out  1  one-clock pulse when TIMEOUT expires.

Function
REQ-020 FSM states IDLE, START, BUSY, GAP, one-hot encoded; illegal encodings return to IDLE.
REQ-021 IDLE, no req: remain IDLE; all outputs hold reset values.
REQ-022 IDLE, exactly one req: grant it.
REQ-023 IDLE, both req: grant the requester not granted last (round-robin pointer); pointer updates on each grant.
REQ-024 On grant: latch winner's len/ip/mac into tx_byte_num/des_ip/des_mac at the same edge that sets grantX and tx_start_en=1; enter START.
REQ-025 Granted len==0: no start; doneX pulses on the next clock; grantX drops with it; enter GAP.
REQ-026 START: tx_start_en stays 1 for exactly START_HOLD clocks, then 0; enter BUSY.
REQ-027 BUSY/START: rd_reqX = tx_req & grantX (combinational); tx_data = granted requester's dataX (combinational); 8'd0 when no grant.
REQ-028 tx_done in START or BUSY: doneX pulses next clock; grantX clears same edge; enter GAP.
REQ-029 A 16-bit watchdog counter runs from grant.
REQ-030 Watchdog reaching TIMEOUT-1 without tx_done: err_timeout pulses one clock; grant clears; no done pulse; enter GAP.
REQ-031 tx_done and timeout on the same clock: tx_done wins; no err_timeout.
REQ-032 tx_done outside START/BUSY: ignored.
REQ-033 GAP: count IFG_CYCLES clocks, then IDLE; requests are not sampled during GAP.
REQ-034 req deasserted after grant: frame still completes; done still pulses.
REQ-035 tx_byte_num/des_ip/des_mac hold their values until the next grant.

Reset
REQ-036 rst_n low at a clock edge forces IDLE, with all outputs 0, counters 0, and the pointer set so that req0 wins the first tie.
REQ-037 Reset mid-frame aborts immediately with no done or err pulse; tx_start_en drops on that edge.

Verification
REQ-038 req0=1, len0=64, ip0=C0A80166 -> grant0 next clock; tx_start_en high 4 clocks; tx_byte_num=64; tx_done -> done0 pulse; 12 gap clocks; back to IDLE.
REQ-039 req0 and req1 both high in IDLE, repeatedly -> grant order 0,1,0,1; never both grants high.
REQ-040 BUSY with grant1, tx_req=1, data1=A5 -> rd_req1=1, rd_req0=0, tx_data=A5 the same clock.
REQ-041 tx_done withheld -> err_timeout pulse exactly TIMEOUT clocks after grant; grant cleared; no done.
REQ-042 req1 with len1=0 -> done1 pulse one clock after grant; tx_start_en never rises.
REQ-043 rst_n low during BUSY -> next edge: all outputs 0, state IDLE; next tie grants req0.

Source files
------------

// File: rtl/udp_tx_arb_if.sv
// Bundle between the two-requester UDP transmit arbiter and its surroundings:
// requester ports on one side, UDP transmitter ports on the other.
interface udp_tx_arb_if;
  logic        req0, req1;
  logic [15:0] len0, len1;
  logic [31:0] ip0, ip1;
  logic [47:0] mac0, mac1;
  logic [7:0]  data0, data1;
  logic        grant0, grant1;
  logic        rd_req0, rd_req1;
  logic        done0, done1;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] des_ip;
  logic [47:0] des_mac;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_done;
  logic        err_timeout;

  modport master (
    input  req0, req1, len0, len1, ip0, ip1, mac0, mac1, data0, data1,
    input  tx_req, tx_done,
    output grant0, grant1, rd_req0, rd_req1, done0, done1,
    output tx_start_en, tx_byte_num, des_ip, des_mac, tx_data, err_timeout
  );

  modport slave (
    output req0, req1, len0, len1, ip0, ip1, mac0, mac1, data0, data1,
    output tx_req, tx_done,
    input  grant0, grant1, rd_req0, rd_req1, done0, done1,
    input  tx_start_en, tx_byte_num, des_ip, des_mac, tx_data, err_timeout
  );
endinterface

// File: rtl/udp_tx_arb.sv
// Round-robin arbiter sharing one UDP transmitter between two frame requesters,
// with start-pulse shaping, a per-frame watchdog and an inter-frame gap.
module udp_tx_arb #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned START_HOLD = 4,
  parameter logic [15:0] TIMEOUT    = 16'd4000
) (
  input logic          clk,
  input logic          rst_n,
  udp_tx_arb_if.master bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    BUSY  = 4'b0100,
    GAP   = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        last_q, last_d;
  logic        zero_len_q, zero_len_d;
  logic        grant0_q, grant0_d;
  logic        grant1_q, grant1_d;
  logic        start_en_q, start_en_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err_q, err_d;
  logic [15:0] byte_num_q, byte_num_d;
  logic [31:0] ip_q, ip_d;
  logic [47:0] mac_q, mac_d;

  logic        pick;
  logic        active;
  logic        wd_expired;
  logic        hold_last;
  logic        gap_last;
  logic [15:0] len_sel;

  // last_q == 1 means requester 1 won most recently, so a tie goes to requester 0.
  assign pick       = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
  assign len_sel    = pick ? bus.len1 : bus.len0;
  assign wd_expired = (wd_cnt_q == (TIMEOUT - 16'd1));
  assign hold_last  = (hold_cnt_q == 4'(START_HOLD - 1));
  assign gap_last   = ((32'(gap_cnt_q) + 32'd1) >= 32'(IFG_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      wd_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      last_q     <= 1'b1;
      zero_len_q <= 1'b0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      start_en_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      byte_num_q <= '0;
      ip_q       <= '0;
      mac_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      last_q     <= last_d;
      zero_len_q <= zero_len_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      start_en_q <= start_en_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err_q      <= err_d;
      byte_num_q <= byte_num_d;
      ip_q       <= ip_d;
      mac_q      <= mac_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    last_d     = last_q;
    zero_len_d = zero_len_q;
    grant0_d   = grant0_q;
    grant1_d   = grant1_q;
    start_en_d = start_en_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err_d      = 1'b0;
    byte_num_d = byte_num_q;
    ip_d       = ip_q;
    mac_d      = mac_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          last_d     = pick;
          grant0_d   = ~pick;
          grant1_d   = pick;
          byte_num_d = len_sel;
          ip_d       = pick ? bus.ip1 : bus.ip0;
          mac_d      = pick ? bus.mac1 : bus.mac0;
          zero_len_d = (len_sel == 16'd0);
          start_en_d = (len_sel != 16'd0);
          hold_cnt_d = '0;
          wd_cnt_d   = '0;
          state_d    = START;
        end
      end

      START, BUSY: begin
        wd_cnt_d = wd_cnt_q + 16'd1;
        if (state_q == START) hold_cnt_d = hold_cnt_q + 4'd1;
        // A completing frame always beats a watchdog expiry on the same clock.
        if (bus.tx_done || (state_q == START && zero_len_q)) begin
          done0_d    = grant0_q;
          done1_d    = grant1_q;
          grant0_d   = 1'b0;
          grant1_d   = 1'b0;
          start_en_d = 1'b0;
          gap_cnt_d  = '0;
          state_d    = GAP;
        end else if (wd_expired) begin
          err_d      = 1'b1;
          grant0_d   = 1'b0;
          grant1_d   = 1'b0;
          start_en_d = 1'b0;
          gap_cnt_d  = '0;
          state_d    = GAP;
        end else if (state_q == START && hold_last) begin
          start_en_d = 1'b0;
          state_d    = BUSY;
        end
      end

      GAP: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_last) state_d = IDLE;
      end

      default: begin
        grant0_d   = 1'b0;
        grant1_d   = 1'b0;
        start_en_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  assign active = (state_q == START) || (state_q == BUSY);

  assign bus.grant0      = grant0_q;
  assign bus.grant1      = grant1_q;
  assign bus.rd_req0     = bus.tx_req & grant0_q & active;
  assign bus.rd_req1     = bus.tx_req & grant1_q & active;
  assign bus.tx_data     = grant0_q ? bus.data0 : (grant1_q ? bus.data1 : 8'd0);
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.tx_start_en = start_en_q;
  assign bus.tx_byte_num = byte_num_q;
  assign bus.des_ip      = ip_q;
  assign bus.des_mac     = mac_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed bench for udp_tx_arb: a vector table for one complete frame plus
// hand-written sequences for gap length, round-robin, timeout, zero length and reset.
module tb_udp_tx_arb;
  localparam logic [15:0] T = 16'd40;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  udp_tx_arb_if bus();

  udp_tx_arb #(.IFG_CYCLES(12), .START_HOLD(4), .TIMEOUT(T)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, req0, req1, tx_req, tx_done;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  // {grant0, grant1, start, done0, done1, rd_req0, rd_req1, err, tx_data, tx_byte_num}
  function automatic logic [31:0] ex(logic g0, logic g1, logic st, logic d0, logic d1,
                                     logic r0, logic r1, logic er, logic [7:0] d,
                                     logic [15:0] bn);
    return {g0, g1, st, d0, d1, r0, r1, er, d, bn};
  endfunction

  function automatic logic [31:0] snap();
    return {bus.grant0, bus.grant1, bus.tx_start_en, bus.done0, bus.done1,
            bus.rd_req0, bus.rd_req1, bus.err_timeout, bus.tx_data, bus.tx_byte_num};
  endfunction

  function automatic vec_t mk(logic r, logic q0, logic q1, logic tr, logic td,
                              logic [31:0] e);
    vec_t v;
    v.rst_n = r; v.req0 = q0; v.req1 = q1; v.tx_req = tr; v.tx_done = td; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok, output int who);
    ok = 1'b0;
    who = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.grant0 && bus.grant1) begin
        check("both_grants", 1, 0);
        break;
      end
      if (bus.grant0 || bus.grant1) begin
        ok = 1'b1;
        who = bus.grant1 ? 1 : 0;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int who;
    int n;
    bit seen_done;
    int order[4];

    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.tx_req = 0; bus.tx_done = 0;
    bus.len0 = 16'd64;  bus.ip0 = 32'hC0A80166; bus.mac0 = 48'h0011_2233_4455;
    bus.len1 = 16'd100; bus.ip1 = 32'h0A000002; bus.mac1 = 48'hAABB_CCDD_EEFF;
    bus.data0 = 8'h3C;  bus.data1 = 8'hA5;

    vecs[0] = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'd0));
    vecs[1] = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'd0));
    vecs[2] = mk(1, 1, 0, 0, 0, ex(1, 0, 1, 0, 0, 0, 0, 0, 8'h3C, 16'd64));
    vecs[3] = mk(1, 1, 0, 0, 0, ex(1, 0, 1, 0, 0, 0, 0, 0, 8'h3C, 16'd64));
    vecs[4] = mk(1, 1, 0, 0, 0, ex(1, 0, 1, 0, 0, 0, 0, 0, 8'h3C, 16'd64));
    vecs[5] = mk(1, 1, 0, 0, 0, ex(1, 0, 1, 0, 0, 0, 0, 0, 8'h3C, 16'd64));
    vecs[6] = mk(1, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 8'h3C, 16'd64));
    vecs[7] = mk(1, 0, 0, 1, 0, ex(1, 0, 0, 0, 0, 1, 0, 0, 8'h3C, 16'd64));
    vecs[8] = mk(1, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 16'd64));
    vecs[9] = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'd64));

    for (int i = 0; i < 10; i++) begin
      rst_n = vecs[i].rst_n;
      bus.req0 = vecs[i].req0;   bus.req1 = vecs[i].req1;
      bus.tx_req = vecs[i].tx_req; bus.tx_done = vecs[i].tx_done;
      tick();
      check($sformatf("vec[%0d]", i), 64'(snap()), 64'(vecs[i].exp));
    end
    check("des_ip0", 64'(bus.des_ip), 64'h0000_0000_C0A8_0166);
    check("des_mac0", 64'(bus.des_mac), 64'h0000_0011_2233_4455);

    // Request during the gap must wait the full 12 idle clocks.
    bus.req1 = 1;
    n = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (bus.grant0 || bus.grant1) n++;
    end
    check("gap_no_grant", 64'(n), 64'd0);
    tick();
    check("gap_grant1", 64'({bus.grant0, bus.grant1, bus.tx_start_en}), 64'b011);
    check("bn1", 64'(bus.tx_byte_num), 64'd100);
    check("des_ip1", 64'(bus.des_ip), 64'h0A00_0002);
    for (int i = 0; i < 3; i++) tick();
    check("start_held", 64'(bus.tx_start_en), 64'd1);
    tick();
    check("start_drop", 64'(bus.tx_start_en), 64'd0);
    bus.tx_req = 1;
    #1;
    check("rd_mux1", 64'({bus.rd_req0, bus.rd_req1, bus.tx_data}), 64'({1'b0, 1'b1, 8'hA5}));
    bus.tx_req = 0; bus.tx_done = 1; bus.req1 = 0;
    tick();
    bus.tx_done = 0;
    check("done1", 64'({bus.done1, bus.grant1, bus.done0}), 64'b100);

    // Round-robin with both requests held: last winner was 1.
    bus.req0 = 1; bus.req1 = 1;
    for (int f = 0; f < 4; f++) begin
      wait_grant(ok, who);
      check($sformatf("rr_wait[%0d]", f), 64'(ok), 64'd1);
      order[f] = who;
      bus.tx_done = 1;
      tick();
      bus.tx_done = 0;
    end
    bus.req0 = 0; bus.req1 = 0;
    check("rr_order", 64'({order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]}),
          64'h0101);

    // Watchdog: no tx_done, so err_timeout must pulse T clocks after the grant.
    bus.req0 = 1;
    wait_grant(ok, who);
    check("to_wait", 64'({ok, who[3:0]}), 64'({1'b1, 4'd0}));
    bus.req0 = 0;
    n = 0;
    seen_done = 0;
    for (int i = 0; i < int'(T) + 10; i++) begin
      tick();
      n++;
      if (bus.done0 || bus.done1) seen_done = 1;
      if (bus.err_timeout) break;
    end
    check("to_clocks", 64'(n), 64'(T));
    check("to_state", 64'({bus.err_timeout, bus.grant0, seen_done}), 64'b100);
    tick();
    check("to_pulse", 64'(bus.err_timeout), 64'd0);

    // Zero-length frame: done next clock, no start.
    bus.len1 = 16'd0; bus.req1 = 1;
    wait_grant(ok, who);
    check("zl_grant", 64'({ok, bus.grant1, bus.tx_start_en, bus.tx_byte_num}),
          64'({1'b1, 1'b1, 1'b0, 16'd0}));
    bus.req1 = 0;
    tick();
    check("zl_done", 64'({bus.done1, bus.grant1, bus.tx_start_en}), 64'b100);

    // Reset while requester 0 is in BUSY; pointer would otherwise favour 1.
    bus.len1 = 16'd100; bus.req0 = 1;
    wait_grant(ok, who);
    check("rst_wait", 64'({ok, who[3:0]}), 64'({1'b1, 4'd0}));
    bus.req0 = 0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 0;
    tick();
    check("rst_outs", 64'(snap()), 64'd0);
    check("rst_dest", 64'({bus.des_ip, bus.des_mac[31:0]}), 64'd0);
    rst_n = 1; bus.req0 = 1; bus.req1 = 1;
    tick();
    check("rst_tie", 64'({bus.grant0, bus.grant1}), 64'b10);
    bus.req0 = 0; bus.req1 = 0; bus.tx_done = 1;
    tick();
    bus.tx_done = 0;
    check("rst_tie_done", 64'(bus.done0), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
